// File: rtl/decode_stage.sv
// Instruction-decode stage of a 5-stage MIPS pipeline.
// Holds the register file, the main control decoder and load-use hazard
// detection, and drives the decode/execute pipeline register.
module decode_stage #(
  parameter int NUM_REGS = 32,
  parameter int DATA_W   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       fd_pc,
  input  logic [31:0]       fd_instr,
  input  logic              flush,
  input  logic              wb_we,
  input  logic [4:0]        wb_rd,
  input  logic [DATA_W-1:0] wb_data,
  output logic              stall,
  output logic [31:0]       de_pc,
  output logic [DATA_W-1:0] de_read1,
  output logic [DATA_W-1:0] de_read2,
  output logic [DATA_W-1:0] de_sign_ext,
  output logic [4:0]        de_rs,
  output logic [4:0]        de_rt,
  output logic [4:0]        de_rd,
  output logic [1:0]        de_wb,
  output logic [2:0]        de_mem,
  output logic [4:0]        de_ex
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  logic [DATA_W-1:0] regs [NUM_REGS];

  logic [5:0]               opcode_p0;
  logic [4:0]               rs_p0;
  logic [4:0]               rt_p0;
  logic [4:0]               rd_p0;
  logic signed [DATA_W-1:0] sext_p0;
  logic [DATA_W-1:0]        read1_p0;
  logic [DATA_W-1:0]        read2_p0;
  logic [1:0]               wb_p0;
  logic [2:0]               mem_p0;
  logic [4:0]               ex_p0;
  logic                     uses_rt_p0;
  logic                     hz_p0;
  logic                     bubble_p0;

  // ---- stage p0: decode of the instruction held in the fetch/decode register
  assign opcode_p0 = fd_instr[31:26];
  assign rs_p0     = fd_instr[25:21];
  assign rt_p0     = fd_instr[20:16];
  assign rd_p0     = fd_instr[15:11];
  assign sext_p0   = {{(DATA_W-16){fd_instr[15]}}, fd_instr[15:0]};

  // Main control decoder; uses_rt marks opcodes that actually read rt as a source.
  always_comb begin
    wb_p0      = 2'b00;
    mem_p0     = 3'b000;
    ex_p0      = 5'b00000;
    uses_rt_p0 = 1'b0;
    case (opcode_p0)
      OP_RTYPE: begin wb_p0 = 2'b10; mem_p0 = 3'b000; ex_p0 = 5'b01010; uses_rt_p0 = 1'b1; end
      OP_LW:    begin wb_p0 = 2'b11; mem_p0 = 3'b100; ex_p0 = 5'b10000; end
      OP_SW:    begin wb_p0 = 2'b00; mem_p0 = 3'b010; ex_p0 = 5'b10000; uses_rt_p0 = 1'b1; end
      OP_BEQ:   begin wb_p0 = 2'b00; mem_p0 = 3'b001; ex_p0 = 5'b00001; uses_rt_p0 = 1'b1; end
      OP_ADDI:  begin wb_p0 = 2'b10; mem_p0 = 3'b000; ex_p0 = 5'b10000; end
      default:  begin wb_p0 = 2'b00; end
    endcase
  end

  // Register-file reads with same-cycle writeback bypass; $0 is hardwired to zero.
  always_comb begin
    read1_p0 = regs[rs_p0];
    read2_p0 = regs[rt_p0];
    if (rs_p0 == 5'd0)
      read1_p0 = '0;
    else if (wb_we && (wb_rd == rs_p0))
      read1_p0 = wb_data;
    if (rt_p0 == 5'd0)
      read2_p0 = '0;
    else if (wb_we && (wb_rd == rt_p0))
      read2_p0 = wb_data;
  end

  // Load-use hazard: a load in execute whose destination is a source of this instruction.
  assign hz_p0 = de_mem[2] && (de_rt != 5'd0) &&
                 ((de_rt == rs_p0) || ((de_rt == rt_p0) && uses_rt_p0));
  assign stall     = hz_p0 & ~flush;
  assign bubble_p0 = stall | flush;

  // Register-file write port; writes continue through stall and flush.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++)
        regs[i] <= '0;
    end else if (wb_we && (wb_rd != 5'd0)) begin
      regs[wb_rd] <= wb_data;
    end
  end

  // ---- stage p1: decode/execute pipeline register, control zeroed on a bubble
  always_ff @(posedge clk) begin
    if (rst) begin
      de_pc       <= '0;
      de_read1    <= '0;
      de_read2    <= '0;
      de_sign_ext <= '0;
      de_rs       <= '0;
      de_rt       <= '0;
      de_rd       <= '0;
      de_wb       <= '0;
      de_mem      <= '0;
      de_ex       <= '0;
    end else begin
      de_pc       <= fd_pc;
      de_read1    <= read1_p0;
      de_read2    <= read2_p0;
      de_sign_ext <= sext_p0;
      de_rs       <= rs_p0;
      de_rt       <= rt_p0;
      de_rd       <= rd_p0;
      de_wb       <= bubble_p0 ? 2'b00    : wb_p0;
      de_mem      <= bubble_p0 ? 3'b000   : mem_p0;
      de_ex       <= bubble_p0 ? 5'b00000 : ex_p0;
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// Directed, table-driven bench for decode_stage.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] fd_pc;
  logic [31:0] fd_instr;
  logic        flush;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        stall;
  logic [31:0] de_pc, de_read1, de_read2, de_sign_ext;
  logic [4:0]  de_rs, de_rt, de_rd;
  logic [1:0]  de_wb;
  logic [2:0]  de_mem;
  logic [4:0]  de_ex;

  int checks   = 0;
  int failures = 0;

  decode_stage dut (
    .clk(clk), .rst(rst), .fd_pc(fd_pc), .fd_instr(fd_instr), .flush(flush),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data), .stall(stall),
    .de_pc(de_pc), .de_read1(de_read1), .de_read2(de_read2),
    .de_sign_ext(de_sign_ext), .de_rs(de_rs), .de_rt(de_rt), .de_rd(de_rd),
    .de_wb(de_wb), .de_mem(de_mem), .de_ex(de_ex)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic        flush;
    logic        we;
    logic [4:0]  wrd;
    logic [31:0] wdata;
    logic        stall;
    logic [1:0]  wb;
    logic [2:0]  mem;
    logic [4:0]  ex;
    logic        chk;
    logic [31:0] r1;
    logic [31:0] r2;
    logic [31:0] se;
  } vec_t;

  vec_t vecs [18];

  function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
    return {6'd0, rs, rt, rd, 5'd0, 6'h20};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic vec_t mk(input logic [31:0] instr, input logic fl, input logic we,
                              input logic [4:0] wrd, input logic [31:0] wdata, input logic st,
                              input logic [1:0] wb, input logic [2:0] mem, input logic [4:0] ex,
                              input logic chk, input logic [31:0] r1, input logic [31:0] r2,
                              input logic [31:0] se);
    vec_t v;
    v.instr = instr; v.flush = fl; v.we = we; v.wrd = wrd; v.wdata = wdata;
    v.stall = st; v.wb = wb; v.mem = mem; v.ex = ex;
    v.chk = chk; v.r1 = r1; v.r2 = r2; v.se = se;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic [31:0] instr, input logic fl,
                       input logic we, input logic [4:0] wrd, input logic [31:0] wdata,
                       input logic [31:0] pc);
    rst = r; fd_instr = instr; flush = fl; wb_we = we; wb_rd = wrd; wb_data = wdata; fd_pc = pc;
  endtask

  task automatic check_ctrl(input string tag, input logic [1:0] wb, input logic [2:0] mem, input logic [4:0] ex);
    check({tag, ".de_wb"},  {30'd0, de_wb},  {30'd0, wb});
    check({tag, ".de_mem"}, {29'd0, de_mem}, {29'd0, mem});
    check({tag, ".de_ex"},  {27'd0, de_ex},  {27'd0, ex});
  endtask

  initial begin
    logic [31:0] lw4, add_dep;
    lw4     = itype(6'b100011, 5'd1, 5'd4, 16'h0000);
    add_dep = rtype(5'd4, 5'd2, 5'd5);

    vecs[0]  = mk(rtype(5, 0, 3), 0, 1, 5, 32'hDEADBEEF, 0, 2'b10, 3'b000, 5'b01010, 1, 32'hDEADBEEF, 0, 32'h00001820);
    vecs[1]  = mk(rtype(5, 7, 3), 0, 0, 0, 0,            0, 2'b10, 3'b000, 5'b01010, 1, 32'hDEADBEEF, 0, 32'h00001820);
    vecs[2]  = mk(rtype(0, 0, 1), 0, 1, 0, 7,            0, 2'b10, 3'b000, 5'b01010, 1, 0, 0, 32'h00000820);
    vecs[3]  = mk(itype(6'b100011, 1, 2, 16'hFFFC), 0, 1, 1, 32'h100, 0, 2'b11, 3'b100, 5'b10000, 1, 32'h100, 0, 32'hFFFFFFFC);
    vecs[4]  = mk(itype(6'b000100, 1, 3, 16'h0003), 0, 0, 0, 0, 0, 2'b00, 3'b001, 5'b00001, 1, 32'h100, 0, 32'h3);
    vecs[5]  = mk(itype(6'b111111, 2, 2, 16'h0000), 0, 0, 0, 0, 0, 2'b00, 3'b000, 5'b00000, 1, 0, 0, 0);
    vecs[6]  = mk(lw4,     0, 0, 0, 0,     0, 2'b11, 3'b100, 5'b10000, 1, 32'h100, 0, 0);
    vecs[7]  = mk(add_dep, 0, 0, 0, 0,     1, 2'b00, 3'b000, 5'b00000, 0, 0, 0, 0);
    vecs[8]  = mk(add_dep, 0, 1, 4, 32'h44, 0, 2'b10, 3'b000, 5'b01010, 1, 32'h44, 0, 32'h00002820);
    vecs[9]  = mk(lw4,     0, 0, 0, 0,     0, 2'b11, 3'b100, 5'b10000, 1, 32'h100, 32'h44, 0);
    vecs[10] = mk(itype(6'b101011, 1, 4, 0), 0, 0, 0, 0, 1, 2'b00, 3'b000, 5'b00000, 0, 0, 0, 0);
    vecs[11] = mk(itype(6'b101011, 1, 4, 0), 0, 0, 0, 0, 0, 2'b00, 3'b010, 5'b10000, 1, 32'h100, 32'h44, 0);
    vecs[12] = mk(lw4,     0, 0, 0, 0,     0, 2'b11, 3'b100, 5'b10000, 1, 32'h100, 32'h44, 0);
    vecs[13] = mk(itype(6'b001000, 6, 4, 1), 0, 0, 0, 0, 0, 2'b10, 3'b000, 5'b10000, 1, 0, 32'h44, 32'h1);
    vecs[14] = mk(lw4,     0, 0, 0, 0,     0, 2'b11, 3'b100, 5'b10000, 1, 32'h100, 32'h44, 0);
    vecs[15] = mk(add_dep, 1, 0, 0, 0,     0, 2'b00, 3'b000, 5'b00000, 0, 0, 0, 0);
    vecs[16] = mk(lw4,     0, 0, 0, 0,     0, 2'b11, 3'b100, 5'b10000, 1, 32'h100, 32'h44, 0);
    vecs[17] = mk(itype(6'b111111, 0, 4, 0), 0, 0, 0, 0, 0, 2'b00, 3'b000, 5'b00000, 1, 0, 32'h44, 0);

    // Reset for two cycles while a lw and a writeback are presented.
    @(negedge clk);
    drive(1, itype(6'b100011, 1, 2, 16'hFFFC), 0, 1, 5, 32'h1234, 32'h10);
    @(posedge clk); @(posedge clk); #1;
    check("rst.stall", {31'd0, stall}, 0);
    check_ctrl("rst", 2'b00, 3'b000, 5'b00000);
    check("rst.de_pc", de_pc, 0);
    check("rst.de_read1", de_read1, 0);
    check("rst.de_sign_ext", de_sign_ext, 0);
    check("rst.de_rt", {27'd0, de_rt}, 0);

    // After release, reg 5 must still be 0 (reset beat the writeback).
    @(negedge clk);
    drive(0, rtype(5, 6, 3), 0, 0, 0, 0, 32'h20);
    @(posedge clk); #1;
    check("post_rst.read1", de_read1, 0);
    check("post_rst.read2", de_read2, 0);

    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      drive(0, vecs[i].instr, vecs[i].flush, vecs[i].we, vecs[i].wrd, vecs[i].wdata, 32'h100 + i);
      #1;
      check($sformatf("v%0d.stall", i), {31'd0, stall}, {31'd0, vecs[i].stall});
      @(posedge clk); #1;
      check_ctrl($sformatf("v%0d", i), vecs[i].wb, vecs[i].mem, vecs[i].ex);
      check($sformatf("v%0d.de_pc", i), de_pc, 32'h100 + i);
      if (vecs[i].chk) begin
        check($sformatf("v%0d.de_read1", i), de_read1, vecs[i].r1);
        check($sformatf("v%0d.de_read2", i), de_read2, vecs[i].r2);
        check($sformatf("v%0d.de_sign_ext", i), de_sign_ext, vecs[i].se);
        check($sformatf("v%0d.de_rt", i), {27'd0, de_rt}, {27'd0, vecs[i].instr[20:16]});
      end
    end

    // Reset asserted in the middle of a load-use stall.
    @(negedge clk);
    drive(0, lw4, 0, 0, 0, 0, 32'h200);
    @(negedge clk);
    drive(0, add_dep, 0, 0, 0, 0, 32'h201);
    #1;
    check("midrst.stall_before", {31'd0, stall}, 1);
    @(negedge clk);
    drive(1, add_dep, 0, 0, 0, 0, 32'h201);
    @(posedge clk); #1;
    check_ctrl("midrst", 2'b00, 3'b000, 5'b00000);
    check("midrst.de_pc", de_pc, 0);
    check("midrst.de_read1", de_read1, 0);
    check("midrst.de_rt", {27'd0, de_rt}, 0);
    check("midrst.stall_after", {31'd0, stall}, 0);

    // Registers written earlier are cleared by the mid-run reset.
    @(negedge clk);
    drive(0, rtype(1, 4, 5), 0, 0, 0, 0, 32'h202);
    #1;
    check("postmid.stall", {31'd0, stall}, 0);
    @(posedge clk); #1;
    check("postmid.read1", de_read1, 0);
    check("postmid.read2", de_read2, 0);
    check_ctrl("postmid", 2'b10, 3'b000, 5'b01010);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
Instruction-decode stage of the 5-stage MIPS pipeline. It sits between the fetch/decode pipeline register and the execute stage. It owns the 32x32 register file, the main control decoder, and load-use hazard detection, and it drives the decode/execute pipeline register. Writeback writes the register file through this block.

Parameters:
NUM_REGS, 32, register file depth (index width fixed at 5 bits)
DATA_W, 32, datapath width

Ports:
clk  in  1  system clock; all state updates on rising edge
rst  in  1  synchronous, active-high reset
fd_pc  in  32  word-addressed PC from fetch/decode register
fd_instr  in  32  instruction from fetch/decode register
flush  in  1  branch taken in memory stage; squash the instruction being decoded
wb_we  in  1  writeback RegWrite
wb_rd  in  5  writeback destination register
wb_data  in  32  writeback data
stall  out  1  combinational; fetch must hold pc and the fetch/decode register
de_pc  out  32  registered PC
de_read1  out  32  registered rs value
de_read2  out  32  registered rt value
de_sign_ext  out  32  registered sign-extended instr[15:0]
de_rs  out  5  registered instr[25:21], used by forwarding
de_rt  out  5  registered instr[20:16]
de_rd  out  5  registered instr[15:11]
de_wb  out  2  {RegWrite, MemToReg}
de_mem  out  3  {MemRead, MemWrite, Branch}
de_ex  out  5  {ALUSrc, RegDst, ALUOp[2:0]}

Behaviour:
- Reset: all de_* outputs are 0, and all 32 registers are cleared to 0. Reset overrides flush, stall, and wb_we in the same cycle.
- Latency: 1 cycle from fd_instr to de_* outputs.
- Decoder, keyed on opcode instr[31:26]:
  - 000000 R-type: wb=10, mem=000, ex=0_1_010
  - 100011 lw: wb=11, mem=100, ex=1_0_000
  - 101011 sw: wb=00, mem=010, ex=1_0_000
  - 000100 beq: wb=00, mem=001, ex=0_0_001
  - 001000 addi: wb=10, mem=000, ex=1_0_000
  - Any other opcode is a NOP: all control bits 0.
- Register file:
  - Write on posedge when wb_we=1 and wb_rd!=0. Register 0 always reads 0.
  - Read bypass: if wb_we=1, wb_rd!=0, and wb_rd equals the read index, the read returns wb_data in the same cycle.
- Sign extend: {{16{instr[15]}}, instr[15:0]}.
- Load-use hazard (hz) is 1 when all of the following hold:
  - de_mem[2]=1 and de_rt!=0
  - de_rt==fd_instr[25:21], or de_rt==fd_instr[20:16] with the decoded opcode being R-type, sw, or beq
- stall = hz & ~flush.
- Bubble: when stall=1 or flush=1, the registered de_wb, de_mem, and de_ex are loaded with 0. The data fields load normally and are don't-care. Exactly one bubble is inserted per stall cycle.
- Flush has priority over stall.
- A NOP opcode never produces a hazard through instr[20:16].
- Register-file writes proceed during stall and flush.

Test Plan:
- Reset: assert rst for 2 cycles while presenting lw -> all de_* outputs are 0 and stall=0. After release, reading any register returns 0.
- Write/read bypass: wb_we=1, wb_rd=5, wb_data=0xDEAD_BEEF, with fd_instr=add $3,$5,$0 in the same cycle -> next cycle de_read1=0xDEADBEEF, de_wb=10, de_ex=01010. Also wb_rd=0 with data 7 -> $0 still reads 0.
- Decode coverage: lw $2,-4($1) -> de_sign_ext=0xFFFFFFFC, de_mem=100, de_wb=11, de_ex=10000. beq -> de_ex=00001, de_mem=001. Opcode 111111 -> all control 0.
- Load-use: lw $4,0($1) followed by add $5,$4,$2 -> stall=1 for exactly 1 cycle and a bubble with control all 0 is registered. The add issues on the next cycle. With sw $4 after lw $4, stall is also 1.
- No false hazard: lw $4 followed by addi $4,$6,1 (rt used only as destination) -> stall=0.
- Flush: flush=1 while a hazard condition is true -> stall=0 and de_wb/de_mem/de_ex are 0. Also assert rst mid-stall -> all outputs 0 on the next cycle and stall drops.
